// File: rtl/hazard_scoreboard.sv
// Interlock scoreboard for long-latency producers: per-register pending-write
// counters drive a RAW/WAW stall into ID and flag unmatched writebacks.
module hazard_scoreboard #(
  parameter int NREGS = 16,
  parameter int CNTW  = 2,
  localparam int IDXW = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [63:0]      id_ir,
  input  logic             id_valid,
  input  logic             id_use_rb,
  input  logic             id_use_rc,
  input  logic [1:0]       id_reg_write,
  input  logic             id_long,
  input  logic             flush_i,
  input  logic             wb_valid,
  input  logic [IDXW-1:0]  wb_reg,
  output logic             stall,
  output logic [NREGS-1:0] busy,
  output logic             err
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [CNTW-1:0]  pend_q [NREGS];
  logic [CNTW-1:0]  pend_d [NREGS];
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] wb_hit;
  logic [NREGS-1:0] eff_nz;
  logic [NREGS-1:0] iss_hit;
  logic [NREGS-1:0] underflow;
  logic [IDXW-1:0]  ra;
  logic [IDXW-1:0]  rb;
  logic [IDXW-1:0]  rc;
  logic             writes;
  logic             issue;
  logic             err_q;
  logic             unused_ir;

  assign ra        = id_ir[20 +: IDXW];
  assign rb        = id_ir[16 +: IDXW];
  assign rc        = id_ir[12 +: IDXW];
  assign unused_ir = ^{id_ir[63:24], id_ir[11:0]};
  assign writes    = |id_reg_write;

  // pend - wb_hit is nonzero exactly when pend differs from the 0/1 hit value,
  // so a same-cycle writeback releases the interlock with no extra cycle.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wb_hit[r] = wb_valid && (wb_reg == IDXW'(r));
      eff_nz[r] = (pend_q[r] != CNTW'(wb_hit[r]));
    end
  end

  always_comb begin
    stall = 1'b0;
    if (rst_i && id_valid && !flush_i) begin
      if (id_use_rb && eff_nz[rb])                  stall = 1'b1;
      if (id_use_rc && eff_nz[rc])                  stall = 1'b1;
      if (writes && eff_nz[ra])                     stall = 1'b1;
      if (writes && id_long && pend_q[ra] == CNT_MAX) stall = 1'b1;
    end
  end

  assign issue = id_valid && !flush_i && !stall && writes && id_long;

  // An issue and a writeback to the same register cancel out, even from zero.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      iss_hit[r]   = issue && (ra == IDXW'(r));
      pend_d[r]    = pend_q[r];
      underflow[r] = 1'b0;
      if (iss_hit[r] && !wb_hit[r]) begin
        pend_d[r] = pend_q[r] + CNTW'(1);
      end else if (!iss_hit[r] && wb_hit[r]) begin
        if (pend_q[r] != '0) pend_d[r] = pend_q[r] - CNTW'(1);
        else underflow[r] = 1'b1;
      end
      busy_d[r] = (pend_d[r] != '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NREGS; r++) pend_q[r] <= '0;
      busy  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) pend_q[r] <= pend_d[r];
      busy  <= busy_d;
      err_q <= err_q | (|underflow);
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a per-cycle vector table plus a hand-driven
// asynchronous reset sequence; busy/err expectations go through a queue.
module tb_hazard_scoreboard;

  typedef struct {
    logic       v;
    logic [3:0] ra, rb, rc;
    logic       urb, urc;
    logic [1:0] rw;
    logic       lg, fl, wbv;
    logic [3:0] wbr;
    logic       exp_stall;
    logic [15:0] exp_busy;
    logic       exp_err;
  } vec_t;

  typedef struct packed {
    logic [15:0] busy;
    logic        err;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [63:0] id_ir = '0;
  logic        id_valid = 1'b0;
  logic        id_use_rb = 1'b0;
  logic        id_use_rc = 1'b0;
  logic [1:0]  id_reg_write = '0;
  logic        id_long = 1'b0;
  logic        flush_i = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_reg = '0;
  logic        stall;
  logic [15:0] busy;
  logic        err;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  hazard_scoreboard #(.NREGS(16), .CNTW(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_ir(id_ir), .id_valid(id_valid),
    .id_use_rb(id_use_rb), .id_use_rc(id_use_rc), .id_reg_write(id_reg_write),
    .id_long(id_long), .flush_i(flush_i), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .stall(stall), .busy(busy), .err(err)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int v, input int ra, input int rb, input int rc,
                     input int urb, input int urc, input int rw, input int lg,
                     input int fl, input int wbv, input int wbr,
                     input int st, input int bsy, input int er);
    vec_t t;
    t.v = v[0]; t.ra = ra[3:0]; t.rb = rb[3:0]; t.rc = rc[3:0];
    t.urb = urb[0]; t.urc = urc[0]; t.rw = rw[1:0]; t.lg = lg[0];
    t.fl = fl[0]; t.wbv = wbv[0]; t.wbr = wbr[3:0];
    t.exp_stall = st[0]; t.exp_busy = bsy[15:0]; t.exp_err = er[0];
    vecs.push_back(t);
  endtask

  // Random filler in the opcode/immediate bits shows they are ignored.
  task automatic apply_stimulus(input vec_t t);
    id_ir        = {$urandom, $urandom};
    id_ir[23:20] = t.ra;
    id_ir[19:16] = t.rb;
    id_ir[15:12] = t.rc;
    id_valid     = t.v;
    id_use_rb    = t.urb;
    id_use_rc    = t.urc;
    id_reg_write = t.rw;
    id_long      = t.lg;
    flush_i      = t.fl;
    wb_valid     = t.wbv;
    wb_reg       = t.wbr;
  endtask

  task automatic check_output(input int idx);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty row %0d: got empty queue expected entry", idx);
    end else begin
      e = exp_q.pop_front();
      check_val($sformatf("busy row %0d", idx), {16'h0, busy}, {16'h0, e.busy});
      check_val($sformatf("err row %0d", idx), {31'h0, err}, {31'h0, e.err});
    end
  endtask

  initial begin
    exp_t e;
    vec_t idle;

    //     v ra rb rc urb urc rw lg fl wbv wbr  stall busy     err
    // load-use RAW on r3, released by the writeback in row 4
    add(1, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 16'h0008, 0);
    add(1, 6, 3, 0, 1, 0, 1, 0, 0, 0, 0,   1, 16'h0008, 0);
    add(1, 6, 3, 0, 1, 0, 1, 0, 0, 0, 0,   1, 16'h0008, 0);
    add(1, 6, 3, 0, 1, 0, 1, 0, 0, 0, 0,   1, 16'h0008, 0);
    add(1, 6, 3, 0, 1, 0, 1, 0, 0, 1, 3,   0, 16'h0000, 0);
    // simultaneous issue and writeback on r5
    add(1, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 16'h0020, 0);
    add(1, 5, 0, 0, 0, 0, 1, 1, 0, 1, 5,   0, 16'h0020, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5,   0, 16'h0000, 0);
    // repeated long writers to r7, each held by WAW until the prior writeback
    add(1, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 16'h0080, 0);
    add(1, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0,   1, 16'h0080, 0);
    add(1, 7, 0, 0, 0, 0, 1, 1, 0, 1, 7,   0, 16'h0080, 0);
    add(1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0,   0, 16'h0080, 0);
    add(1, 0, 0, 7, 0, 1, 0, 0, 0, 0, 0,   1, 16'h0080, 0);
    add(1, 7, 0, 0, 0, 0, 1, 1, 0, 1, 7,   0, 16'h0080, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 16'h0000, 0);
    // underflow on r9 sets the sticky error
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9,   0, 16'h0000, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 16'h0000, 1);
    // flush squashes a stalled long writer; non-long writer stalls on WAW
    add(1, 2, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 16'h0004, 1);
    add(1, 8, 2, 0, 1, 0, 1, 1, 1, 0, 0,   0, 16'h0004, 1);
    add(1, 8, 2, 0, 1, 0, 1, 1, 0, 0, 0,   1, 16'h0004, 1);
    add(1, 2, 0, 0, 0, 0, 2, 0, 0, 0, 0,   1, 16'h0004, 1);

    idle = '{v:0, ra:0, rb:0, rc:0, urb:0, urc:0, rw:0, lg:0, fl:0, wbv:0,
             wbr:0, exp_stall:0, exp_busy:0, exp_err:0};

    // reset held with a would-be stall presented: outputs must stay quiet
    id_valid = 1'b1; id_use_rb = 1'b1; wb_valid = 1'b1; wb_reg = 4'd0;
    repeat (2) @(posedge clk_i);
    #1;
    check_val("reset stall", {31'h0, stall}, 32'h0);
    check_val("reset busy", {16'h0, busy}, 32'h0);
    check_val("reset err", {31'h0, err}, 32'h0);
    apply_stimulus(idle);
    #2 rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      e.busy = vecs[i].exp_busy;
      e.err  = vecs[i].exp_err;
      exp_q.push_back(e);
      #2;
      check_val($sformatf("stall row %0d", i), {31'h0, stall}, {31'h0, vecs[i].exp_stall});
      @(posedge clk_i);
      #1;
      check_output(i);
    end

    // async reset with r2 and r4 pending
    apply_stimulus(idle);
    id_valid = 1'b1; id_ir[23:20] = 4'd4; id_reg_write = 2'd1; id_long = 1'b1;
    @(posedge clk_i);
    #1;
    check_val("pre-reset busy", {16'h0, busy}, 32'h0014);
    apply_stimulus(idle);
    id_valid = 1'b1; id_ir[19:16] = 4'd2; id_use_rb = 1'b1;
    #1;
    check_val("pre-reset stall", {31'h0, stall}, 32'h1);
    #1 rst_i = 1'b0;
    #1;
    check_val("mid reset busy", {16'h0, busy}, 32'h0);
    check_val("mid reset stall", {31'h0, stall}, 32'h0);
    check_val("mid reset err", {31'h0, err}, 32'h0);
    #1 rst_i = 1'b1;
    #1;
    check_val("post reset stall", {31'h0, stall}, 32'h0);
    apply_stimulus(idle);
    wb_valid = 1'b1; wb_reg = 4'd2;
    @(posedge clk_i);
    #1;
    apply_stimulus(idle);
    check_val("late wb err", {31'h0, err}, 32'h1);
    check_val("late wb busy", {16'h0, busy}, 32'h0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Interlock companion to the operand forwarding unit.
- Forwarding covers single-cycle producers in EXE/MEM. This block tracks long-latency producers (loads, multi-cycle ALU ops), whose results are not available for forwarding.
- Keeps a per-register pending-write count, set at issue from ID and cleared at writeback.
- Drives a stall to the ID stage for RAW and WAW conflicts against those in-flight writes.

Parameters:
- NREGS, 16, number of architectural registers; the index width is clog2(NREGS) and is 4 at the default.
- CNTW, 2, pending-counter width per register; the maximum number of outstanding writes per register is 2**CNTW-1.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-low.
- id_ir  input  64  instruction in ID. ra=[23:20], rb=[19:16], rc=[15:12].
- id_valid  input  1  ID holds a real instruction.
- id_use_rb  input  1  instruction reads rb.
- id_use_rc  input  1  instruction reads rc.
- id_reg_write  input  2  nonzero means the instruction writes ra.
- id_long  input  1  instruction is a long-latency producer (writes back via the wb port).
- flush_i  input  1  squash the ID instruction this cycle.
- wb_valid  input  1  long-latency writeback completes this cycle.
- wb_reg  input  4  destination register of that writeback.
- stall  output  1  hold the PC/IF/ID registers and inject a bubble into EXE.
- busy  output  NREGS  registered; bit r is 1 when pend[r] != 0.
- err  output  1  sticky flag: writeback arrived for a register with pend==0.

Behaviour:
- State: pend[r], CNTW bits, one per register; err_q, 1 bit.
- Reset (rst_i low, async):
  - All pend[r]=0, err=0, busy=0.
  - stall=0 while reset is asserted.
  - Reset mid-operation discards every outstanding count. Late writebacks that arrive after reset raise err; this is expected and the bench must tolerate it.
- Writeback-adjusted count, combinational: eff[r] = pend[r] - (wb_valid && wb_reg==r).
  - A writeback in the same cycle releases the stall with no extra cycle (zero-latency clear).
- stall is combinational. It is 1 when id_valid && !flush_i and any of:
  - id_use_rb && eff[rb] != 0 (RAW on rb);
  - id_use_rc && eff[rc] != 0 (RAW on rc);
  - |id_reg_write && eff[ra] != 0 (WAW; keeps writeback order correct);
  - |id_reg_write && id_long && pend[ra] == max (saturation guard).
- Issue: issue = id_valid && !flush_i && !stall && |id_reg_write && id_long.
- Per-register next-state update (per register r):
  - Issue to r only: pend[r] += 1.
  - Writeback to r only: if pend[r] != 0, pend[r] -= 1; otherwise pend[r] stays 0 and err_q is set.
  - Issue and writeback to the same r in the same cycle: pend[r] is unchanged and err is not set, even if pend was 0.
  - Issue and writeback to different registers in the same cycle: both updates apply independently.
- Counters never wrap:
  - Overflow is prevented by the saturation stall.
  - Underflow is blocked and flagged through err.
- err is sticky until reset.
- busy[r] is registered from the pend next-state, so it is visible one cycle after the update.
- flush_i has priority over everything:
  - no issue and stall=0 that cycle;
  - writebacks are still processed.
- Non-long writers (id_long=0) never set pend; they rely on the forwarder.
  - They still stall on WAW against a pending long write to the same ra.
- r0 has no special treatment; every register is tracked.

Test Plan:
- Load-use RAW:
  - Stimulus: issue a long op writing r3. Next cycle, ID reads rb=3 with id_use_rb=1. Assert wb_valid/wb_reg=3 four cycles later.
  - Required: stall=1 for 3 cycles, stall=0 in the wb cycle, instruction issues, pend[3]=0, busy[3]=0 the cycle after.
- Simultaneous issue and wb:
  - Stimulus: pend[5]=1. Same cycle: a long op to r5 that is not stalled (eff[5]=0) plus wb to r5.
  - Required: pend[5] stays 1, err=0.
- Saturation:
  - Stimulus: three independent long writers to r7, each separated by its own wb.
  - Required: the WAW stall holds each one until its predecessor's wb arrives. pend[7] never exceeds 1. No stall on rc when id_use_rc=0.
- Underflow:
  - Stimulus: wb_valid=1, wb_reg=9 with pend[9]=0.
  - Required: err=1 next cycle and it stays 1. pend[9]=0.
- Flush:
  - Stimulus: id_valid=1, flush_i=1, RAW conflict present.
  - Required: stall=0, no pend change.
- Async reset mid-flight:
  - Stimulus: pend[2]=1, pend[4]=1; pulse rst_i low between clock edges.
  - Required: busy=0 immediately, stall=0. A subsequent wb to r2 sets err=1.
